ioport_pcint: RTL and testbench



---
 rtl/ioport_pcint_pkg.sv | 23 ++
 rtl/ioport_pcint_io_sync2.sv | 23 ++
 rtl/ioport_pcint.sv | 117 +++++++++++
 tb/tb_ioport_pcint.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ioport_pcint_pkg.sv
// Shared AVR port address map, default pin-change register addresses and bus widths.
package ioport_pcint_pkg;

    localparam int unsigned ADR_W  = 6;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADR_W-1:0] PCMSK_BASE = 6'h0C;
    localparam logic [ADR_W-1:0] PCIF_BASE  = 6'h0D;

    // Each port owns three consecutive addresses: PIN, DDR, PORT (port A at 0).
    function automatic logic [ADR_W-1:0] port_pin(input int unsigned number);
        return ADR_W'(3 * number);
    endfunction

    function automatic logic [ADR_W-1:0] port_ddr(input int unsigned number);
        return ADR_W'(3 * number + 1);
    endfunction

    function automatic logic [ADR_W-1:0] port_address(input int unsigned number);
        return ADR_W'(3 * number + 2);
    endfunction

endpackage

// File: rtl/ioport_pcint_io_sync2.sv
// Two-flop synchroniser for asynchronous inputs, synchronous active-low reset.
module io_sync2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ioport_pcint.sv
// AVR I/O port with PORT/DDR/PIN registers, PIN-write toggle and masked pin-change interrupt.
module ioport_pcint
    import ioport_pcint_pkg::*;
#(
    parameter int unsigned      NUMBER  = 0,
    parameter int unsigned      BITS    = 8,
    parameter bit               ENA_OUT = 1'b1,
    parameter bit               ENA_IN  = 1'b1,
    parameter logic [ADR_W-1:0] MSK_ADR = PCMSK_BASE,
    parameter logic [ADR_W-1:0] FLG_ADR = PCIF_BASE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ena_i,
    input  logic [ADR_W-1:0]  adr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    input  logic              re_i,
    input  logic              we_i,
    output logic              selected_o,
    output logic              irq_o,
    input  logic              irq_ack_i,
    input  logic [BITS-1:0]   port_i,
    output logic [BITS-1:0]   port_o,
    output logic [BITS-1:0]   port_oe_o
);

    localparam logic [ADR_W-1:0] PORT_ADR = port_address(NUMBER);
    localparam logic [ADR_W-1:0] DDR_ADR  = port_ddr(NUMBER);
    localparam logic [ADR_W-1:0] PIN_ADR  = port_pin(NUMBER);
    localparam bit               DDR_IMPL = ENA_OUT && ENA_IN;
    localparam bit               DDR_ONES = ENA_OUT && !ENA_IN;

    logic [BITS-1:0] port_q, ddr_q, msk_q, flg_q, hist_q, sync_q;
    logic            irq_q;
    logic [BITS-1:0] port_nxt, ddr_nxt, msk_nxt, flg_nxt, clr, chg;
    logic            hit_port, hit_ddr, hit_pin, hit_msk, hit_flg, wr;
    logic            unused_data;

    assign unused_data = ^data_i;

    io_sync2 #(.W(BITS)) u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (port_i),
        .q     (sync_q)
    );

    // Address decode and next-state for all registers.
    always_comb begin
        hit_port = ENA_OUT && (adr_i == PORT_ADR);
        hit_ddr  = ENA_OUT && (adr_i == DDR_ADR);
        hit_pin  = ENA_IN  && (adr_i == PIN_ADR);
        hit_msk  = ENA_IN  && (adr_i == MSK_ADR);
        hit_flg  = ENA_IN  && (adr_i == FLG_ADR);
        wr       = we_i && ena_i;

        port_nxt = port_q;
        ddr_nxt  = ddr_q;
        msk_nxt  = msk_q;
        clr      = '0;

        // Toggle is checked first so it wins if PIN and PORT ever alias.
        if (wr && hit_pin && ENA_OUT) begin
            port_nxt = port_q ^ data_i[BITS-1:0];
        end else if (wr && hit_port) begin
            port_nxt = data_i[BITS-1:0];
        end
        if (wr && hit_ddr && DDR_IMPL) begin
            ddr_nxt = data_i[BITS-1:0];
        end
        if (wr && hit_msk) begin
            msk_nxt = data_i[BITS-1:0];
        end
        if (wr && hit_flg) begin
            clr = data_i[BITS-1:0];
        end
        if (irq_ack_i && ena_i) begin
            clr = '1;
        end

        // A change in the same cycle as a clear keeps its flag.
        chg     = (sync_q ^ hist_q) & msk_q;
        flg_nxt = (flg_q & ~clr) | chg;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            port_q <= '0;
            ddr_q  <= '0;
            msk_q  <= '0;
            flg_q  <= '0;
            hist_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            port_q <= port_nxt;
            ddr_q  <= ddr_nxt;
            msk_q  <= msk_nxt;
            flg_q  <= flg_nxt;
            hist_q <= sync_q;
            irq_q  <= |flg_nxt;
        end
    end

    assign port_o    = port_q;
    assign port_oe_o = DDR_ONES ? {BITS{1'b1}} : ddr_q;
    assign irq_o     = irq_q;

    assign data_o = ({DATA_W{hit_port}} & DATA_W'(port_q))
                  | ({DATA_W{hit_ddr}}  & DATA_W'(port_oe_o))
                  | ({DATA_W{hit_pin}}  & DATA_W'(sync_q))
                  | ({DATA_W{hit_msk}}  & DATA_W'(msk_q))
                  | ({DATA_W{hit_flg}}  & DATA_W'(flg_q));

    assign selected_o = re_i && (hit_port || hit_ddr || hit_pin || hit_msk || hit_flg);

endmodule

// File: tb/tb_ioport_pcint.sv
// Bench for ioport_pcint: directed scenarios plus randomized traffic against a behavioural model.
module tb_ioport_pcint;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ena, we, re, ack;
    logic [5:0] adr;
    logic [7:0] din, pins;
    logic [7:0] dout, pout, poe;
    logic       sel, irq;
    logic [7:0] dout4;
    logic [3:0] pout4, poe4;
    logic       sel4, irq4;

    ioport_pcint dut (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .adr_i(adr), .data_i(din),
        .data_o(dout), .re_i(re), .we_i(we), .selected_o(sel), .irq_o(irq),
        .irq_ack_i(ack), .port_i(pins), .port_o(pout), .port_oe_o(poe)
    );

    ioport_pcint #(.NUMBER(1), .BITS(4), .ENA_OUT(1'b1), .ENA_IN(1'b0)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .adr_i(adr), .data_i(din),
        .data_o(dout4), .re_i(re), .we_i(we), .selected_o(sel4), .irq_o(irq4),
        .irq_ack_i(ack), .port_i(pins[3:0]), .port_o(pout4), .port_oe_o(poe4)
    );

    int total = 0;
    int bad   = 0;

    // Model state: registers as the CPU sees them, plus the per-edge pin sample history.
    logic [7:0] m_port, m_ddr, m_msk, m_flg;
    logic [3:0] m4_port;
    logic [7:0] smp[$];
    bit         armed = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Pin value visible to the CPU lags the pins by two sampling edges.
    function automatic logic [7:0] m_sync2();
        return smp[smp.size()-2];
    endfunction

    task automatic check_comb();
        logic [7:0] e, e4;
        logic       es, es4;
        if (armed) begin
            e = 8'h00; es = 1'b1;
            case (adr)
                6'h00:   e = m_sync2();
                6'h01:   e = m_ddr;
                6'h02:   e = m_port;
                6'h0C:   e = m_msk;
                6'h0D:   e = m_flg;
                default: es = 1'b0;
            endcase
            e4 = 8'h00; es4 = 1'b1;
            case (adr)
                6'h04:   e4 = 8'h0F;
                6'h05:   e4 = {4'h0, m4_port};
                default: es4 = 1'b0;
            endcase
            if (re) begin
                chk("data_o", dout, e);
                chk("data_o bits4", dout4, e4);
            end
            chk("selected_o", {7'b0, sel}, {7'b0, es && re});
            chk("selected_o bits4", {7'b0, sel4}, {7'b0, es4 && re});
        end
    endtask

    task automatic check_regs();
        chk("port_o", pout, m_port);
        chk("port_oe_o", poe, m_ddr);
        chk("irq_o", {7'b0, irq}, {7'b0, m_flg != 8'h00});
        chk("port_o bits4", {4'h0, pout4}, {4'h0, m4_port});
        chk("port_oe_o bits4", {4'h0, poe4}, 8'h0F);
        chk("irq_o bits4", {7'b0, irq4}, 8'h00);
    endtask

    task automatic model_step();
        logic [7:0] chg, clr;
        logic       w;
        if (!rst_n) begin
            m_port = 8'h00; m_ddr = 8'h00; m_msk = 8'h00; m_flg = 8'h00; m4_port = 4'h0;
            smp = '{8'h00, 8'h00, 8'h00};
            armed = 1'b1;
        end else begin
            w = we && ena;
            // Flag sets when the synchronised pin differs from its value one edge earlier.
            chg = (smp[smp.size()-2] ^ smp[smp.size()-3]) & m_msk;
            clr = 8'h00;
            if (w && adr == 6'h0D) clr = din;
            if (ack && ena) clr = 8'hFF;
            m_flg = (m_flg & ~clr) | chg;
            if (w && adr == 6'h00) m_port = m_port ^ din;
            else if (w && adr == 6'h02) m_port = din;
            if (w && adr == 6'h01) m_ddr = din;
            if (w && adr == 6'h0C) m_msk = din;
            if (w && adr == 6'h05) m4_port = din[3:0];
            smp.push_back(pins);
            if (smp.size() > 4) void'(smp.pop_front());
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic w, input logic rd,
                       input logic [5:0] a, input logic [7:0] d, input logic k, input logic [7:0] p);
        rst_n = r; ena = e; we = w; re = rd; adr = a; din = d; ack = k; pins = p;
        #1 check_comb();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle(input logic [7:0] p);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'h3F, 8'h00, 1'b0, p);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d, input logic [7:0] p);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, a, d, 1'b0, p);
    endtask

    task automatic peek(input logic [5:0] a);
        re = 1'b1; we = 1'b0; ack = 1'b0; adr = a;
        #1;
    endtask

    logic [5:0] adrs [9];
    logic [7:0] p;

    initial begin
        adrs = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h0C, 6'h0D, 6'h3F};
        rst_n = 1'b0; ena = 1'b1; we = 1'b1; re = 1'b0; ack = 1'b0;
        adr = 6'h02; din = 8'hFF; pins = 8'h00;
        smp = '{8'h00, 8'h00, 8'h00};
        m_port = 8'h00; m_ddr = 8'h00; m_msk = 8'h00; m_flg = 8'h00; m4_port = 4'h0;
        @(negedge clk);

        // Reset beats a simultaneous PORT write.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 6'h02, 8'hFF, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 6'h02, 8'hFF, 1'b1, 8'h00);
        chk("reset port_o", pout, 8'h00);
        chk("reset port_oe_o", poe, 8'h00);
        chk("reset irq_o", {7'b0, irq}, 8'h00);

        idle(8'h5A);
        peek(6'h00);
        chk("pin read after 1 edge", dout, 8'h00);
        idle(8'h5A);
        peek(6'h00);
        chk("pin read after 2 edges", dout, 8'h5A);
        idle(8'h00);

        // PIN write toggles PORT, DDR untouched.
        wr(6'h01, 8'h3C, 8'h00);
        wr(6'h02, 8'hA5, 8'h00);
        wr(6'h00, 8'h0F, 8'h00);
        chk("toggle port_o", pout, 8'hAA);
        chk("toggle port_oe_o", poe, 8'h3C);
        idle(8'h00);
        idle(8'h00);

        // Rising edge on pin 0, flag appears exactly two edges after sampling.
        wr(6'h0C, 8'h01, 8'h00);
        idle(8'h01);
        chk("pcint irq edge N", {7'b0, irq}, 8'h00);
        idle(8'h01);
        chk("pcint irq edge N+1", {7'b0, irq}, 8'h00);
        idle(8'h01);
        chk("pcint irq edge N+2", {7'b0, irq}, 8'h01);
        peek(6'h0D);
        chk("pcint flags", dout, 8'h01);
        idle(8'h03);
        idle(8'h03);
        idle(8'h03);
        idle(8'h01);
        idle(8'h01);
        idle(8'h01);
        peek(6'h0D);
        chk("masked pin no flag", dout, 8'h01);

        // Clear of bits 0/1 coincides with a new change on bit 1.
        wr(6'h0C, 8'h03, 8'h01);
        idle(8'h03);
        idle(8'h03);
        idle(8'h03);
        peek(6'h0D);
        chk("both flags set", dout, 8'h03);
        idle(8'h01);
        idle(8'h01);
        wr(6'h0D, 8'h03, 8'h01);
        peek(6'h0D);
        chk("clear race flags", dout, 8'h02);
        chk("clear race irq", {7'b0, irq}, 8'h01);

        // Acknowledge only counts with the CPU enable.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 6'h3F, 8'h00, 1'b1, 8'h01);
        peek(6'h0D);
        chk("ack without ena", dout, 8'h02);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'h3F, 8'h00, 1'b1, 8'h01);
        chk("ack irq_o", {7'b0, irq}, 8'h00);
        peek(6'h0D);
        chk("ack flags", dout, 8'h00);

        // Four-bit output-only port.
        wr(6'h05, 8'hFF, 8'h01);
        peek(6'h05);
        chk("bits4 port read", dout4, 8'h0F);
        peek(6'h03);
        chk("bits4 pin selected", {7'b0, sel4}, 8'h00);
        chk("bits4 irq", {7'b0, irq4}, 8'h00);

        // Randomized traffic.
        p = 8'h01;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) p = p ^ 8'($urandom);
            cyc($urandom_range(0, 79) != 0, $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                adrs[$urandom_range(0, 8)], 8'($urandom),
                $urandom_range(0, 9) == 0, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
